// File: rtl/rr_arbiter.sv
// Round-robin arbiter: NUM valid/ready inputs share one output, optional eot transaction lock.
// Define RR_ARBITER_OUT_REG_EN to insert a 2-entry registered buffer in front of dout_*.
module rr_arbiter #(
  parameter int NUM      = 2,
  parameter int DIN      = 16,
  parameter bit EOT_LOCK = 1'b1,
  localparam int IDX_W   = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM-1:0]       din_valid,
  output logic [NUM-1:0]       din_ready,
  input  logic [NUM*DIN-1:0]   din_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [IDX_W+DIN-1:0] dout_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] prio_ptr_q, prio_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;

  logic [2*NUM-1:0] valid_dbl;
  logic [NUM-1:0]   valid_rot;
  logic             search_hit;
  int unsigned      sel_off;
  int unsigned      sel_sum;
  logic [IDX_W-1:0] search_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] ptr_next;
  logic             win_valid;
  logic [DIN-1:0]   win_data;
  logic             core_valid;
  logic             core_ready;
  logic             xfer;
  logic             last;

  // Rotate the request vector so offset 0 is the current priority holder.
  // NOTE: every variable written in always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    valid_dbl  = {din_valid, din_valid} >> prio_ptr_q;
    valid_rot  = valid_dbl[NUM-1:0];
    search_hit = 1'b0;
    sel_off    = 0;
    for (int off = 0; off < NUM; off++) begin
      if (!search_hit && valid_rot[off]) begin
        search_hit = 1'b1;
        sel_off    = off;
      end
    end
    sel_sum = int'(prio_ptr_q) + sel_off;
    if (sel_sum >= NUM) sel_sum = sel_sum - NUM;
    search_idx = IDX_W'(sel_sum);
  end

  assign winner   = (state_q == IDLE) ? search_idx : grant_q;
  assign ptr_next = (winner == IDX_W'(NUM - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    win_valid = 1'b0;
    win_data  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (winner == IDX_W'(i)) begin
        win_valid = din_valid[i];
        win_data  = din_data[i*DIN +: DIN];
      end
    end
  end

  // A cycle with rst asserted presents nothing and accepts nothing.
  assign core_valid = !rst && ((state_q == IDLE) ? search_hit : win_valid);
  assign xfer       = core_valid && core_ready;
  assign last       = (EOT_LOCK == 1'b0) || win_data[DIN-1];

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      din_ready[i] = !rst && (winner == IDX_W'(i)) && core_ready &&
                     ((state_q != IDLE) || search_hit);
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_ptr_d = prio_ptr_q;
    grant_d    = grant_q;
    if (xfer) begin
      if (last) begin
        prio_ptr_d = ptr_next;
        state_d    = IDLE;
      end else begin
        grant_d = winner;
        state_d = LOCKED;
      end
    end else if (core_valid && (state_q == IDLE)) begin
      // Pin the source so a stalled word cannot be swapped for another input.
      grant_d = winner;
      state_d = HOLD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_ptr_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      grant_q    <= grant_d;
    end
  end

`ifdef RR_ARBITER_OUT_REG_EN
  logic [IDX_W+DIN-1:0] buf_q [2];
  logic [1:0]           cnt_q;
  logic                 wr_q;
  logic                 rd_q;
  logic                 pop;

  assign core_ready = (cnt_q != 2'd2);
  assign pop        = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      if (xfer) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(xfer) - 2'(pop);
    end
  end

  // NOTE: the data storage is not reset; occupancy is tracked by cnt_q alone,
  // so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (xfer) buf_q[wr_q] <= {winner, win_data};
  end

  assign dout_valid = (cnt_q != 2'd0);
  assign dout_data  = buf_q[rd_q];
`else
  assign core_ready = dout_ready;
  assign dout_valid = core_valid;
  assign dout_data  = {winner, win_data};
`endif

endmodule
